// File: rtl/cb_hazard_gate.sv
// -----------------------------------------------------------------------------
// cb_hazard_gate
//
// Request-stream gate that sits directly upstream of a counting bloom filter.
// Each request is looked up in the filter and held back while its data may
// already be in flight. A forwarded request increments the filter and is
// recorded in an in-order FIFO. Each completion pops the FIFO head and
// decrements the filter. A flush drains all outstanding entries and then
// clears the filter.
//
// Optional feature macro: CB_HAZARD_STALL_CNT_EN
//   defined   : stall_cnt_o counts RUN cycles with req_valid_i & look_valid_i
//               (saturating, cleared by reset and by the CLEAR state)
//   undefined : stall_cnt_o is tied to 0
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_*                  upstream request (valid/ready/data)
//   fwd_*                  downstream request (valid/ready/data)
//   cpl_valid_i            in-order completion pulse
//   flush_i / flush_done_o flush request level / completion pulse
//   look_*                 filter lookup data / hit
//   incr_*, decr_*         filter increment / decrement
//   filter_clear_o         filter clear
//   filter_full_i          filter bucket full
//   outstanding_o          FIFO occupancy
//   err_o                  sticky: completion with nothing outstanding
//   stall_cnt_o            hazard stall cycle counter
// -----------------------------------------------------------------------------
module cb_hazard_gate #(
    parameter int DataWidth = 32,
    parameter int Depth     = 8,
    localparam int CntWidth = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [DataWidth-1:0] req_data_i,
    output logic                 fwd_valid_o,
    input  logic                 fwd_ready_i,
    output logic [DataWidth-1:0] fwd_data_o,
    input  logic                 cpl_valid_i,
    input  logic                 flush_i,
    output logic                 flush_done_o,
    output logic [DataWidth-1:0] look_data_o,
    input  logic                 look_valid_i,
    output logic [DataWidth-1:0] incr_data_o,
    output logic                 incr_valid_o,
    output logic [DataWidth-1:0] decr_data_o,
    output logic                 decr_valid_o,
    output logic                 filter_clear_o,
    input  logic                 filter_full_i,
    output logic [CntWidth-1:0]  outstanding_o,
    output logic                 err_o,
    output logic [31:0]          stall_cnt_o
);

    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_CLEAR
    } state_t;

    state_t                state;
    logic [DataWidth-1:0]  mem [Depth];
    logic [PtrWidth-1:0]   rd_ptr;
    logic [PtrWidth-1:0]   wr_ptr;
    logic [CntWidth-1:0]   count;

    logic stall;
    logic run_open;
    logic accept;
    logic pop;
    logic drain_done;

    // Pointers wrap explicitly so Depth need not be a power of two.
    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // A full FIFO stalls even if a pop happens in the same cycle.
    assign stall      = look_valid_i | filter_full_i | (count == CntWidth'(Depth));
    // Accepts stop in the very cycle a flush is requested.
    assign run_open   = (state == ST_RUN) & ~flush_i;
    assign fwd_valid_o = req_valid_i & ~stall & run_open;
    assign req_ready_o = fwd_ready_i & ~stall & run_open;
    assign accept     = fwd_valid_o & fwd_ready_i;
    assign pop        = cpl_valid_i & (count != '0) & (state != ST_CLEAR);
    // No accepts happen in DRAIN, so a pop of the last entry empties the FIFO.
    assign drain_done = (count == '0) | ((count == CntWidth'(1)) & pop);

    assign fwd_data_o    = req_data_i;
    assign look_data_o   = req_data_i;
    assign incr_valid_o  = accept;
    assign incr_data_o   = req_data_i;
    assign decr_valid_o  = pop;
    assign decr_data_o   = mem[rd_ptr];
    assign outstanding_o = count;

    // NOTE: the storage array has no reset; only pointers and count qualify
    // its contents, so resetting it would add muxes for no behavioural gain.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem[wr_ptr] <= req_data_i;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            err_o  <= 1'b0;
        end else begin
            if (cpl_valid_i && ((count == '0) || (state == ST_CLEAR))) begin
                err_o <= 1'b1;
            end
            if (state == ST_CLEAR) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (pop)    rd_ptr <= next_ptr(rd_ptr);
                if (accept) wr_ptr <= next_ptr(wr_ptr);
                if (accept && !pop)      count <= count + 1'b1;
                else if (pop && !accept) count <= count - 1'b1;
            end
        end
    end

    // Flush FSM; clear/done are registered and high exactly in CLEAR.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= ST_RUN;
            flush_done_o   <= 1'b0;
            filter_clear_o <= 1'b0;
        end else begin
            flush_done_o   <= 1'b0;
            filter_clear_o <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (flush_i) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state          <= ST_CLEAR;
                        flush_done_o   <= 1'b1;
                        filter_clear_o <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef CB_HAZARD_STALL_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
        end else if (state == ST_CLEAR) begin
            stall_cnt_o <= '0;
        end else if (req_valid_i && look_valid_i && (state == ST_RUN) &&
                     (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`else
    assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_cb_hazard_gate.sv
// -----------------------------------------------------------------------------
// tb_cb_hazard_gate
//
// Scoreboard bench for cb_hazard_gate. The stimulus process drives inputs
// shortly after each rising edge, asks a queue-based reference model what the
// DUT must present this cycle, and pushes that expectation. A monitor samples
// the DUT on the falling edge and compares against the popped expectation.
// -----------------------------------------------------------------------------
module tb_cb_hazard_gate;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [DW-1:0] req_data_i = '0;
    logic          fwd_valid_o;
    logic          fwd_ready_i = 1'b0;
    logic [DW-1:0] fwd_data_o;
    logic          cpl_valid_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          flush_done_o;
    logic [DW-1:0] look_data_o;
    logic          look_valid_i = 1'b0;
    logic [DW-1:0] incr_data_o;
    logic          incr_valid_o;
    logic [DW-1:0] decr_data_o;
    logic          decr_valid_o;
    logic          filter_clear_o;
    logic          filter_full_i = 1'b0;
    logic [CW-1:0] outstanding_o;
    logic          err_o;
    logic [31:0]   stall_cnt_o;

    always #5 clk_i = ~clk_i;

    cb_hazard_gate #(.DataWidth(DW), .Depth(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
        .fwd_valid_o(fwd_valid_o), .fwd_ready_i(fwd_ready_i), .fwd_data_o(fwd_data_o),
        .cpl_valid_i(cpl_valid_i), .flush_i(flush_i), .flush_done_o(flush_done_o),
        .look_data_o(look_data_o), .look_valid_i(look_valid_i),
        .incr_data_o(incr_data_o), .incr_valid_o(incr_valid_o),
        .decr_data_o(decr_data_o), .decr_valid_o(decr_valid_o),
        .filter_clear_o(filter_clear_o), .filter_full_i(filter_full_i),
        .outstanding_o(outstanding_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o)
    );

    typedef struct {
        bit          req_ready;
        bit          fwd_valid;
        logic [31:0] data;
        bit          incr_valid;
        bit          decr_valid;
        logic [31:0] decr_data;
        bit          clear;
        int          outstanding;
        bit          err;
        logic [31:0] stall_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: outstanding data in order, flush phase, sticky error.
    typedef enum int {M_RUN, M_DRAIN, M_CLEAR} mode_t;
    logic [31:0] mq[$];
    mode_t       mode   = M_RUN;
    bit          err_m  = 0;
    logic [31:0] sc_m   = 0;
    bit          last_acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_flight(input logic [31:0] d);
        foreach (mq[i]) if (mq[i] == d) return 1;
        return 0;
    endfunction

    // One clock cycle of stimulus plus the model's expectation for it.
    task automatic step(input bit rst, input bit rv, input logic [31:0] d, input bit fr,
                        input bit cpl, input bit fl, input bit lk, input bit fu);
        exp_t e;
        bit   stall, open, acc, pop;
        int   n;
        @(posedge clk_i);
        #1;
        if (rst) begin
            rv = 0; fr = 0; cpl = 0; fl = 0; lk = 0; fu = 0; d = '0;
            mq.delete(); mode = M_RUN; err_m = 0; sc_m = 0;
        end
        rst_ni = !rst; req_valid_i = rv; req_data_i = d; fwd_ready_i = fr;
        cpl_valid_i = cpl; flush_i = fl; look_valid_i = lk; filter_full_i = fu;

        n     = mq.size();
        stall = lk || fu || (n == DEPTH);
        open  = (mode == M_RUN) && !fl;
        e.fwd_valid   = rv && !stall && open;
        e.req_ready   = fr && !stall && open;
        acc           = e.fwd_valid && fr;
        pop           = cpl && n > 0 && mode != M_CLEAR;
        e.data        = d;
        e.incr_valid  = acc;
        e.decr_valid  = pop;
        e.decr_data   = (n > 0) ? mq[0] : '0;
        e.clear       = (mode == M_CLEAR);
        e.outstanding = n;
        e.err         = err_m;
`ifdef CB_HAZARD_STALL_CNT_EN
        e.stall_cnt   = sc_m;
`else
        e.stall_cnt   = 0;
`endif
        exp_q.push_back(e);
        last_acc = acc;
        if (rst) return;

        if (cpl && (n == 0 || mode == M_CLEAR)) err_m = 1;
        if (mode == M_CLEAR) sc_m = 0;
        else if (rv && lk && mode == M_RUN && sc_m != 32'hFFFF_FFFF) sc_m = sc_m + 1;
        case (mode)
            M_RUN:   if (fl) mode = M_DRAIN;
            M_DRAIN: if (n == 0 || (n == 1 && pop)) mode = M_CLEAR;
            default: mode = M_RUN;
        endcase
        if (e.clear) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic send(input logic [31:0] d);
        step(0, 1, d, 1, 0, 0, 0, 0);
    endtask

    task automatic complete(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    // Monitor: compares whatever the DUT presents against the oldest expectation.
    always @(negedge clk_i) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("req_ready", req_ready_o, e.req_ready);
            check("fwd_valid", fwd_valid_o, e.fwd_valid);
            check("incr_valid", incr_valid_o, e.incr_valid);
            check("decr_valid", decr_valid_o, e.decr_valid);
            check("filter_clear", filter_clear_o, e.clear);
            check("flush_done", flush_done_o, e.clear);
            check("outstanding", outstanding_o, e.outstanding);
            check("err", err_o, e.err);
            check("stall_cnt", stall_cnt_o, e.stall_cnt);
            check("look_data", look_data_o, e.data);
            if (e.fwd_valid)  check("fwd_data", fwd_data_o, e.data);
            if (e.incr_valid) check("incr_data", incr_data_o, e.data);
            if (e.decr_valid) check("decr_data", decr_data_o, e.decr_data);
        end
    end

    initial begin
        bit          pend = 0;
        bit          fl = 0;
        logic [31:0] pd = 0;
        bit          rv, lk, fu, fr, cpl;

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // Back-to-back same data: accepted, then held while the filter hits.
        send(32'h10);
        step(0, 1, 32'h10, 1, 0, 0, 1, 0);
        step(0, 1, 32'h10, 1, 0, 0, 1, 0);
        send(32'h10);
        complete(2);

        // In-order completions.
        send(32'hA); send(32'hB); send(32'hC);
        complete(3);

        // Full FIFO stalls even with a same-cycle completion.
        for (int i = 0; i < DEPTH; i++) send(32'h20 + i);
        step(0, 1, 32'h30, 1, 1, 0, 0, 0);
        send(32'h30);
        complete(DEPTH);

        // Simultaneous accept and completion.
        send(32'h3);
        step(0, 1, 32'h5, 1, 1, 0, 0, 0);
        complete(1);

        // Flush with two outstanding.
        send(32'h40); send(32'h41);
        step(0, 1, 32'h42, 1, 0, 1, 0, 0);
        step(0, 1, 32'h42, 1, 1, 1, 0, 0);
        step(0, 1, 32'h42, 1, 1, 1, 0, 0);
        step(0, 1, 32'h42, 1, 0, 0, 0, 0);
        send(32'h42);
        complete(1);

        // Held flush with an empty FIFO: DRAIN then CLEAR straight away.
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Five hit cycles on the stall counter.
        for (int i = 0; i < 5; i++) step(0, 1, 32'h77, 1, 0, 0, 1, 0);
        idle(1);

        // Completion with empty FIFO: sticky error until reset.
        complete(1);
        idle(3);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Randomized traffic with an in-flight-aware filter model.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                step(1, 0, 0, 0, 0, 0, 0, 0);
                pend = 0; fl = 0;
                continue;
            end
            if (!pend && ($urandom % 3 != 0)) begin
                pend = 1;
                pd = $urandom % 12;
            end
            rv  = pend;
            lk  = in_flight(pd) || ($urandom % 10 == 0);
            fu  = ($urandom % 20 == 0);
            fr  = ($urandom % 4 != 0);
            cpl = (mq.size() > 0) ? ($urandom % 3 == 0) : ($urandom % 400 == 0);
            if (mode == M_RUN && !fl && ($urandom % 60 == 0)) fl = 1;
            if (mode == M_CLEAR) fl = 0;
            step(0, rv, pd, fr, cpl, fl, lk, fu);
            if (last_acc) pend = 0;
        end
        idle(2);

        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk_i);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
